irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Single-level interrupt controller between external interrupt lines and the microcontroller's control unit.
- Synchronises and edge-detects four asynchronous request lines, latches them as pending and applies a software-written mask.
- Presents one prioritised request with a jump vector to the control unit and captures the return PC on acknowledge.
- Holds that return PC until end-of-interrupt.

Parameters:
VEC_BASE, 8'hF0, vector address of source 0
VEC_STRIDE, 8'h04, address distance between consecutive source vectors

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
irq  in  4  asynchronous interrupt lines, rising-edge significant
mask_we  in  1  write strobe for mask register
mask_din  in  4  new mask value (bit=1 enables source), driven from ACC
pc_in  in  8  current PC from program counter
int_ack  in  1  control unit accepts request at instruction boundary (1-cycle pulse)
eoi  in  1  end-of-interrupt (return instruction executed, 1-cycle pulse)
int_req  out  1  interrupt request to control unit
vector  out  8  jump target, valid while int_req=1
ret_pc  out  8  PC captured at acknowledge
in_service  out  4  one-hot source currently being serviced
pending  out  4  latched pending sources
mask  out  4  current mask register

Behaviour:
- Reset (async, immediate): state IDLE, all outputs and internal regs 0, including synchroniser flops, vector, ret_pc and mask (all sources disabled).
- Synchroniser per line: s1<=irq, s2<=s1, s3<=s2; edge=s2&~s3.
  - Line high before edge 0 sets pending at edge 2.
  - Pulses shorter than one clk period are not guaranteed to be caught.
- pending[i] is set on edge[i] regardless of mask and state. It is cleared only when source i is acknowledged.
  - Simultaneous ack-clear and new edge on the same bit: bit stays 1 (new event kept).
- mask: loaded from mask_din when mask_we=1, in any state; effective next cycle.
- eligible = pending & mask. Priority: lowest index wins (irq[0] highest).
- FSM IDLE:
  - If eligible!=0: latch sel=highest-priority eligible index, vector<=VEC_BASE+sel*VEC_STRIDE (8-bit, wraps mod 256), int_req<=1, go to REQ.
  - int_req therefore asserts 1 cycle after pending&mask becomes nonzero.
- FSM REQ:
  - sel and vector are frozen; newly arriving higher-priority sources do not replace them.
  - On int_ack: ret_pc<=pc_in, pending[sel]<=0 (subject to the edge rule above), in_service<=onehot(sel), int_req<=0, go to SERVICE.
  - If mask[sel] goes 0 with no int_ack that cycle: int_req<=0, go to IDLE (withdraw); pending[sel] stays set.
  - int_ack in the same cycle as withdraw: ack wins.
- FSM SERVICE:
  - No nesting; new edges accumulate in pending only.
  - On eoi: in_service<=0, go to IDLE; re-arbitration may raise int_req the following cycle.
  - ret_pc holds its value until the next acknowledge.
- Ignored inputs: int_ack in IDLE/SERVICE; eoi in IDLE/REQ; int_ack and eoi asserted together are treated per current state only.
- vector retains its last value when int_req=0.
- Outputs are all registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset/basic: rst pulse mid-SERVICE with mask=4'hF, in_service=4'b0100 -> all outputs 0 immediately, state IDLE; an irq edge afterwards is ignored until mask rewritten.
- Single source: mask=4'b0100, irq[2] rises before edge 0 -> pending=4'b0100 after edge 2, int_req=1 and vector=8'hF8 after edge 3. int_ack with pc_in=8'h37 -> ret_pc=8'h37, in_service=4'b0100, pending=0, int_req=0. eoi -> in_service=0.
- Priority/freeze: mask=4'hF, irq[3] and irq[1] rise together -> vector=8'hF4. irq[0] rises while in REQ -> vector stays 8'hF4. After ack and eoi, next request vector=8'hF0, then 8'hFC.
- Masked pending: mask=0, irq[2] edge -> pending=4'b0100, int_req stays 0. Write mask=4'b0100 -> int_req=1 two cycles after mask_we.
- Withdraw: in REQ for source 1, write mask=0 with no ack -> int_req=0, state IDLE, pending[1]=1. Repeat with int_ack in the same cycle as mask_we -> acknowledge accepted.
- Edge during ack / no nesting: second irq[1] edge aligned with int_ack of source 1 -> pending[1] stays 1. In SERVICE, int_req stays 0. After eoi, int_req=1 again with vector=8'hF4.

Source files
------------

// File: rtl/irq_controller.sv
// Single-level interrupt controller. It synchronises and edge-detects four request lines,
// keeps them pending, masks and prioritises them, and holds the return PC for one handler.
module irq_controller #(
    parameter logic [7:0] VEC_BASE   = 8'hF0,
    parameter logic [7:0] VEC_STRIDE = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_din,
    input  logic [7:0] pc_in,
    input  logic       int_ack,
    input  logic       eoi,
    output logic       int_req,
    output logic [7:0] vector,
    output logic [7:0] ret_pc,
    output logic [3:0] in_service,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t     state;
    logic [3:0] s1, s2, s3;
    logic [3:0] edge_det;
    logic [3:0] eligible;
    logic [3:0] ack_clr;
    logic [1:0] sel;
    logic [1:0] prio;

    assign edge_det = s2 & ~s3;
    assign eligible = pending & mask;
    assign ack_clr  = (state == REQ && int_ack) ? (4'b0001 << sel) : 4'b0000;

    // Scan from the top down so the lowest set index is the one that sticks.
    always_comb begin
        prio = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) prio = 2'(i);
        end
    end

    // NOTE: every register here, including the synchroniser, is reset so a reset
    // mid-edge cannot leave a stale edge behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Clearing on acknowledge comes before the OR, so an edge arriving in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | edge_det;
            if (mask_we) mask <= mask_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            int_req    <= 1'b0;
            vector     <= '0;
            ret_pc     <= '0;
            in_service <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != 4'b0000) begin
                        sel     <= prio;
                        vector  <= VEC_BASE + {6'b0, prio} * VEC_STRIDE;
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        ret_pc     <= pc_in;
                        in_service <= 4'b0001 << sel;
                        int_req    <= 1'b0;
                        state      <= SERVICE;
                    end else if (!mask[sel]) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        in_service <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed and random stimulus for irq_controller, compared every cycle against a
// source-index based model of the controller.
module tb_irq_controller;

    localparam int VEC_BASE   = 'hF0;
    localparam int VEC_STRIDE = 'h04;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_din = '0;
    logic [7:0] pc_in = '0;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       int_req;
    logic [7:0] vector;
    logic [7:0] ret_pc;
    logic [3:0] in_service;
    logic [3:0] pending;
    logic [3:0] mask;

    int checks   = 0;
    int failures = 0;

    // Model: history of sampled irq values (h[0] newest) plus the requested and serviced source.
    logic [3:0] h [3];
    int         m_req;
    int         m_svc;
    logic [7:0] m_vec;
    logic [7:0] m_ret;
    logic [3:0] m_pend;
    logic [3:0] m_mask;

    irq_controller #(.VEC_BASE(8'hF0), .VEC_STRIDE(8'h04)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .pc_in(pc_in), .int_ack(int_ack), .eoi(eoi), .int_req(int_req),
        .vector(vector), .ret_pc(ret_pc), .in_service(in_service),
        .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) h[i] = '0;
        m_req = -1; m_svc = -1;
        m_vec = '0; m_ret = '0; m_pend = '0; m_mask = '0;
    endtask

    task automatic compare_model();
        chk("int_req", {7'b0, int_req}, {7'b0, (m_req >= 0)});
        chk("vector", vector, m_vec);
        chk("ret_pc", ret_pc, m_ret);
        chk("in_service", {4'b0, in_service}, (m_svc >= 0) ? 8'(1 << m_svc) : 8'h00);
        chk("pending", {4'b0, pending}, {4'b0, m_pend});
        chk("mask", {4'b0, mask}, {4'b0, m_mask});
    endtask

    // Advance one clock: predict from the inputs presented now, then compare after the edge.
    task automatic step();
        logic [3:0] edges, clr, elig;
        int nreq, nsvc;
        bit found;
        edges = h[1] & ~h[2];
        clr   = '0;
        elig  = m_pend & m_mask;
        nreq  = m_req;
        nsvc  = m_svc;
        if (m_req >= 0) begin
            if (int_ack) begin
                m_ret = pc_in;
                nsvc = m_req;
                clr[m_req] = 1'b1;
                nreq = -1;
            end else if (!m_mask[m_req]) begin
                nreq = -1;
            end
        end else if (m_svc >= 0) begin
            if (eoi) nsvc = -1;
        end else if (elig != 4'b0000) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (elig[i] && !found) begin
                    nreq = i;
                    found = 1'b1;
                end
            end
            m_vec = 8'((VEC_BASE + nreq * VEC_STRIDE) % 256);
        end
        m_pend = (m_pend & ~clr) | edges;
        if (mask_we) m_mask = mask_din;
        h[2] = h[1]; h[1] = h[0]; h[0] = irq;
        m_req = nreq; m_svc = nsvc;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (!int_req && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_req", {7'b0, int_req}, 8'd1);
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we = 1'b1; mask_din = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic ack(input logic [7:0] pc);
        pc_in = pc; int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic end_irq();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    // Pulse reset between clock edges and check the asynchronous clear before the next edge.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_int_req", {7'b0, int_req}, 8'h00);
        chk("rst_vector", vector, 8'h00);
        chk("rst_ret_pc", ret_pc, 8'h00);
        chk("rst_in_service", {4'b0, in_service}, 8'h00);
        chk("rst_pending", {4'b0, pending}, 8'h00);
        chk("rst_mask", {4'b0, mask}, 8'h00);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single source on line 2.
        write_mask(4'b0100);
        irq = 4'b0100;
        steps(3);
        chk("single_pending", {4'b0, pending}, 8'h04);
        step();
        chk("single_req", {7'b0, int_req}, 8'd1);
        chk("single_vec", vector, 8'hF8);
        ack(8'h37);
        chk("single_ret", ret_pc, 8'h37);
        chk("single_isr", {4'b0, in_service}, 8'h04);
        chk("single_pend_clr", {4'b0, pending}, 8'h00);
        chk("single_req_drop", {7'b0, int_req}, 8'd0);
        end_irq();
        chk("single_eoi", {4'b0, in_service}, 8'h00);
        irq = '0;
        steps(4);

        // Priority and freeze of the selected source.
        write_mask(4'hF);
        irq = 4'b1010;
        wait_req(8);
        chk("prio_vec", vector, 8'hF4);
        irq = 4'b1011;
        steps(4);
        chk("freeze_vec", vector, 8'hF4);
        chk("freeze_req", {7'b0, int_req}, 8'd1);
        ack(8'h11);
        chk("prio_isr", {4'b0, in_service}, 8'h02);
        end_irq();
        step();
        chk("next_vec0", vector, 8'hF0);
        ack(8'h22);
        end_irq();
        step();
        chk("next_vec3", vector, 8'hFC);
        ack(8'h33);
        end_irq();
        irq = '0;
        steps(4);

        // Pending while masked, then unmasked.
        write_mask(4'b0000);
        irq = 4'b0100;
        steps(4);
        chk("masked_pend", {4'b0, pending}, 8'h04);
        chk("masked_noreq", {7'b0, int_req}, 8'd0);
        write_mask(4'b0100);
        chk("unmask_t1", {7'b0, int_req}, 8'd0);
        step();
        chk("unmask_t2", {7'b0, int_req}, 8'd1);
        ack(8'h44);
        end_irq();
        irq = '0;
        steps(4);

        // Withdraw by masking, then ack racing the mask write.
        write_mask(4'b0010);
        irq = 4'b0010;
        wait_req(8);
        write_mask(4'b0000);
        step();
        chk("withdraw_req", {7'b0, int_req}, 8'd0);
        chk("withdraw_pend", {4'b0, pending}, 8'h02);
        write_mask(4'b0010);
        wait_req(4);
        mask_we = 1'b1; mask_din = 4'b0000; pc_in = 8'h55; int_ack = 1'b1;
        step();
        mask_we = 1'b0; int_ack = 1'b0;
        chk("race_isr", {4'b0, in_service}, 8'h02);
        chk("race_ret", ret_pc, 8'h55);
        end_irq();

        // New edge landing on the acknowledge; no nesting while in service.
        write_mask(4'b0010);
        irq = '0;
        steps(4);
        irq = 4'b0010;
        wait_req(8);
        irq = '0;
        steps(3);
        irq = 4'b0010;
        steps(2);
        ack(8'h66);
        chk("edge_ack_pend", {4'b0, pending}, 8'h02);
        chk("edge_ack_isr", {4'b0, in_service}, 8'h02);
        steps(3);
        chk("nonest_req", {7'b0, int_req}, 8'd0);
        end_irq();
        step();
        chk("reraise_req", {7'b0, int_req}, 8'd1);
        chk("reraise_vec", vector, 8'hF4);
        ack(8'h77);
        end_irq();

        // Reset in the middle of servicing source 2.
        write_mask(4'hF);
        irq = 4'b0100;
        wait_req(8);
        ack(8'h88);
        chk("pre_rst_isr", {4'b0, in_service}, 8'h04);
        do_reset();
        steps(4);
        chk("post_rst_pend", {4'b0, pending}, 8'h04);
        chk("post_rst_noreq", {7'b0, int_req}, 8'd0);
        write_mask(4'hF);
        step();
        chk("post_rst_req", {7'b0, int_req}, 8'd1);
        ack(8'h99);
        end_irq();

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 5) == 0) irq = irq ^ 4'($urandom);
            mask_we  = ($urandom_range(0, 15) == 0);
            mask_din = 4'($urandom);
            int_ack  = ($urandom_range(0, 3) == 0);
            eoi      = ($urandom_range(0, 3) == 0);
            pc_in    = 8'($urandom);
            step();
        end
        mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
